// File: rtl/ifu_fetch.sv
// PC register and instruction-fetch sequencer: fetches the word at pc over a
// req/rvalid handshake, hands it to decode, then loads the supplied next PC.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        fetch_err,
    output logic [1:0]  err_code,
    output logic [31:0] err_pc
);

    localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        E_NONE     = 2'd0,
        E_MISALIGN = 2'd1,
        E_RANGE    = 2'd2,
        E_TIMEOUT  = 2'd3
    } err_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   instr_q, instr_d;
    err_t          err_code_q, err_code_d;
    logic [31:0]   err_pc_q, err_pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    err_t          chk_pc, chk_next;

    // Misalignment is reported ahead of range so a bad low-bit jump is never masked.
    function automatic err_t addr_check(input logic [31:0] a);
        err_t res;
        res = E_NONE;
        if (a[1:0] != 2'b00) begin
            res = E_MISALIGN;
        end else if ((a < IM_BASE) || (a > IM_LIMIT)) begin
            res = E_RANGE;
        end
        return res;
    endfunction

    assign chk_pc   = addr_check(pc_q);
    assign chk_next = addr_check(pc_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            err_code_q <= E_NONE;
            err_pc_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            err_code_q <= err_code_d;
            err_pc_q   <= err_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        err_code_d = err_code_q;
        err_pc_d   = err_pc_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (chk_pc != E_NONE) begin
                    state_d    = S_ERR;
                    err_code_d = chk_pc;
                    err_pc_d   = pc_q;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                // A response on the last counted cycle still beats the timeout.
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = S_ERR;
                    err_code_d = E_TIMEOUT;
                    err_pc_d   = pc_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_d = pc_next;
                    if (chk_next != E_NONE) begin
                        state_d    = S_ERR;
                        err_code_d = chk_next;
                        err_pc_d   = pc_next;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == S_REQ);
    assign instr_valid = (state_q == S_HOLD);
    assign fetch_err   = (state_q == S_ERR);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign err_code    = err_code_q;
    assign err_pc      = err_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: transaction-level memory/decode model with
// randomized latency, backpressure and jump targets, plus directed fault cases.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] BASE   = 32'h0000_3000;
    localparam logic [31:0] LIMIT  = 32'h0000_6FFC;
    localparam int          TMO    = 16;

    logic        clk;
    logic        reset;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fetch_err;
    logic [1:0]  err_code;
    logic [31:0] err_pc;

    int n_checks;
    int n_fail;

    ifu_fetch #(
        .RESET_PC (RST_PC),
        .IM_BASE  (BASE),
        .IM_LIMIT (LIMIT),
        .TIMEOUT  (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .instr       (instr),
        .fetch_err   (fetch_err),
        .err_code    (err_code),
        .err_pc      (err_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected fault code for a fetch address, straight from the legality rules.
    function automatic logic [1:0] ref_code(input logic [31:0] a);
        if ((a % 4) != 0) return 2'd1;
        if ((a < BASE) || (a > LIMIT)) return 2'd2;
        return 2'd0;
    endfunction

    // Leaves the bench at the sampling point of the first cycle after reset.
    task automatic reset_dut();
        @(negedge clk);
        reset       = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        pc_next     = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at the sampling point of the request cycle; returns in the cycle after the response.
    task automatic respond(input logic [31:0] d, input int delay);
        repeat (1 + delay) @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
    endtask

    task automatic accept(input logic [31:0] nxt);
        instr_ready = 1'b1;
        pc_next     = nxt;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_next     = $urandom;
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", fetch_err); end
        n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); end
        n_checks++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RST_PC); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", instr); end
        n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", err_code); end
        n_checks++; if (err_pc !== 32'h0) begin n_fail++; $display("FAIL reset_errpc: got %h expected 0", err_pc); end
    endtask

    // Cycle-stepped transaction model: req one cycle after accept (cycle 1 after reset),
    // HOLD one cycle after the response, pc follows each accepted pc_next.
    task automatic test_stream(input int ncyc, input int max_delay, input int ready_pct,
                               input bit seq_pc, input bit fixed_data, input bit check_rate);
        logic [31:0] exp_addr, exp_data, nxt;
        int          req_due, drive_at, hold_at, n_fetch, n_obs;
        bit          exp_req, exp_valid;
        exp_addr = RST_PC;
        exp_data = '0;
        req_due  = 1;
        drive_at = -1;
        hold_at  = -1;
        n_fetch  = 0;
        n_obs    = 0;
        reset_dut();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            exp_req   = (cyc == req_due);
            exp_valid = (hold_at >= 0) && (cyc >= hold_at);
            n_checks++; if (imem_req !== exp_req) begin n_fail++; $display("FAIL stream_req cyc %0d: got %b expected %b", cyc, imem_req, exp_req); end
            n_checks++; if (instr_valid !== exp_valid) begin n_fail++; $display("FAIL stream_valid cyc %0d: got %b expected %b", cyc, instr_valid, exp_valid); end
            n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL stream_err cyc %0d: got %b expected 0", cyc, fetch_err); end
            n_checks++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL stream_addr cyc %0d: got %h expected %h", cyc, imem_addr, exp_addr); end
            n_checks++; if (pc !== exp_addr) begin n_fail++; $display("FAIL stream_pc cyc %0d: got %h expected %h", cyc, pc, exp_addr); end
            if (exp_valid) begin
                n_checks++; if (instr !== exp_data) begin n_fail++; $display("FAIL stream_instr cyc %0d: got %h expected %h", cyc, instr, exp_data); end
            end
            if (instr_valid === 1'b1) n_obs++;

            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            instr_ready = 1'($urandom_range(0, 1));
            pc_next     = $urandom;
            if (exp_req) begin
                drive_at = cyc + 1 + int'($urandom_range(0, max_delay));
                if (fixed_data && n_fetch == 0) exp_data = 32'h3C01_0001;
                else if (fixed_data && n_fetch == 1) exp_data = 32'h0000_0000;
                else exp_data = $urandom;
                n_fetch++;
            end
            if (cyc == drive_at) begin
                imem_rvalid = 1'b1;
                imem_rdata  = exp_data;
                hold_at     = cyc + 1;
                drive_at    = -1;
            end else if (exp_req || exp_valid || cyc < req_due) begin
                imem_rvalid = 1'($urandom_range(0, 1));
            end
            if (exp_valid) begin
                instr_ready = ($urandom_range(0, 99) < ready_pct);
                if (instr_ready) begin
                    nxt      = seq_pc ? exp_addr + 32'd4 : BASE + 32'd4 * $urandom_range(0, 32'hFFF);
                    pc_next  = nxt;
                    exp_addr = nxt;
                    req_due  = cyc + 1;
                    hold_at  = -1;
                end
            end
            @(negedge clk);
        end
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        if (check_rate) begin
            n_checks++; if (n_obs !== (ncyc - 1) / 3) begin n_fail++; $display("FAIL stream_rate: got %0d holds expected %0d", n_obs, (ncyc - 1) / 3); end
        end
    endtask

    task automatic test_back_to_back();
        test_stream(31, 0, 100, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_random_stream();
        test_stream(600, 4, 60, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        bit          seen;
        logic [31:0] d;
        reset_dut();
        wait_req(seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_req_seen: got %b expected 1", seen); end
        d = $urandom;
        respond(d, 0);
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %b expected 1", instr_valid); end
        for (int i = 0; i < 5; i++) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~d;
            instr_ready = 1'b0;
            pc_next     = $urandom;
            @(negedge clk);
            n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid %0d: got %b expected 1", i, instr_valid); end
            n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL bp_pc %0d: got %h expected %h", i, pc, RST_PC); end
            n_checks++; if (instr !== d) begin n_fail++; $display("FAIL bp_instr %0d: got %h expected %h", i, instr, d); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_noreq %0d: got %b expected 0", i, imem_req); end
        end
        imem_rvalid = 1'b0;
        accept(32'h0000_3100);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL bp_jump_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0000_3100) begin n_fail++; $display("FAIL bp_jump_addr: got %h expected 00003100", imem_addr); end
    endtask

    task automatic test_err_jump();
        bit seen;
        reset_dut();
        wait_req(seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL jmp_req_seen: got %b expected 1", seen); end
        respond($urandom, 0);
        accept(32'h0000_3002);
        for (int i = 0; i < 12; i++) begin
            n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL jmp_err %0d: got %b expected 1", i, fetch_err); end
            n_checks++; if (err_code !== 2'd1) begin n_fail++; $display("FAIL jmp_code %0d: got %0d expected 1", i, err_code); end
            n_checks++; if (err_pc !== 32'h0000_3002) begin n_fail++; $display("FAIL jmp_errpc %0d: got %h expected 00003002", i, err_pc); end
            n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL jmp_noreq %0d: got %b expected 0", i, imem_req); end
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_novalid %0d: got %b expected 0", i, instr_valid); end
            instr_ready = ~instr_ready;
            imem_rvalid = ~imem_rvalid;
            imem_rdata  = $urandom;
            pc_next     = BASE;
            @(negedge clk);
        end
        instr_ready = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    task automatic test_range();
        logic [31:0] cases [8] = '{32'h0000_2FFC, 32'h0000_7000, 32'hFFFF_FFFC, 32'h0000_3001,
                                   32'h0000_7002, 32'h0000_6FFC, 32'h0000_3000, 32'h0000_0000};
        logic [1:0]  exp_code;
        logic [31:0] d;
        bit          seen;
        for (int i = 0; i < 8; i++) begin
            reset_dut();
            wait_req(seen);
            n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rng_req_seen %0d: got %b expected 1", i, seen); end
            respond($urandom, 0);
            accept(cases[i]);
            exp_code = ref_code(cases[i]);
            if (exp_code != 2'd0) begin
                n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL rng_err %h: got %b expected 1", cases[i], fetch_err); end
                n_checks++; if (err_code !== exp_code) begin n_fail++; $display("FAIL rng_code %h: got %0d expected %0d", cases[i], err_code, exp_code); end
                n_checks++; if (err_pc !== cases[i]) begin n_fail++; $display("FAIL rng_errpc: got %h expected %h", err_pc, cases[i]); end
            end else begin
                n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rng_ok_req %h: got %b expected 1", cases[i], imem_req); end
                n_checks++; if (imem_addr !== cases[i]) begin n_fail++; $display("FAIL rng_ok_addr: got %h expected %h", imem_addr, cases[i]); end
                d = $urandom;
                respond(d, 0);
                n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rng_ok_hold %h: got %b expected 1", cases[i], instr_valid); end
                n_checks++; if (instr !== d) begin n_fail++; $display("FAIL rng_ok_instr: got %h expected %h", instr, d); end
            end
        end
    endtask

    task automatic test_timeout();
        bit          seen;
        int          n;
        logic [31:0] d;
        reset_dut();
        wait_req(seen);
        respond($urandom, 0);
        accept(32'h0000_4444);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL tmo_req: got %b expected 1", imem_req); end
        n = 0;
        while (fetch_err !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++; if (n !== TMO + 1) begin n_fail++; $display("FAIL tmo_cycles: got %0d expected %0d", n, TMO + 1); end
        n_checks++; if (err_code !== 2'd3) begin n_fail++; $display("FAIL tmo_code: got %0d expected 3", err_code); end
        n_checks++; if (err_pc !== 32'h0000_4444) begin n_fail++; $display("FAIL tmo_errpc: got %h expected 00004444", err_pc); end

        reset_dut();
        wait_req(seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL tmo_last_seen: got %b expected 1", seen); end
        d = $urandom;
        respond(d, TMO - 1);
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL tmo_last_hold: got %b expected 1", instr_valid); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL tmo_last_err: got %b expected 0", fetch_err); end
        n_checks++; if (instr !== d) begin n_fail++; $display("FAIL tmo_last_instr: got %h expected %h", instr, d); end
    endtask

    task automatic test_reset_wait();
        bit          seen;
        logic [31:0] d;
        reset_dut();
        wait_req(seen);
        respond($urandom, 0);
        accept(32'h0000_5000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL rw_pc: got %h expected %h", pc, RST_PC); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rw_idle_req: got %b expected 0", imem_req); end
        @(negedge clk);
        imem_rvalid = 1'b0;
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rw_fresh_req: got %b expected 1", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rw_novalid: got %b expected 0", instr_valid); end
        n_checks++; if (imem_addr !== RST_PC) begin n_fail++; $display("FAIL rw_addr: got %h expected %h", imem_addr, RST_PC); end
        d = $urandom;
        respond(d, 0);
        n_checks++; if (instr !== d) begin n_fail++; $display("FAIL rw_instr: got %h expected %h", instr, d); end
    endtask

    task automatic test_reset_err();
        bit          seen;
        logic [31:0] d;
        reset_dut();
        wait_req(seen);
        respond($urandom | 32'h1, 0);
        accept(32'h0000_7000);
        n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL re_err_set: got %b expected 1", fetch_err); end
        reset_dut();
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL re_err_clr: got %b expected 0", fetch_err); end
        n_checks++; if (err_code !== 2'd0) begin n_fail++; $display("FAIL re_code: got %0d expected 0", err_code); end
        n_checks++; if (err_pc !== 32'h0) begin n_fail++; $display("FAIL re_errpc: got %h expected 0", err_pc); end
        n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL re_instr: got %h expected 0", instr); end
        n_checks++; if (pc !== RST_PC) begin n_fail++; $display("FAIL re_pc: got %h expected %h", pc, RST_PC); end
        wait_req(seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL re_resume_req: got %b expected 1", seen); end
        d = $urandom;
        respond(d, 1);
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL re_resume_hold: got %b expected 1", instr_valid); end
        n_checks++; if (instr !== d) begin n_fail++; $display("FAIL re_resume_instr: got %h expected %h", instr, d); end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        pc_next     = '0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_back_to_back();
        test_random_stream();
        test_backpressure();
        test_err_jump();
        test_range();
        test_timeout();
        test_reset_wait();
        test_reset_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
